// File: rtl/steg_pkg.sv
// Definitions shared by the message-hiding datapath: digit width, the illegal
// base-3 code, and the serializer state encoding.
package steg_pkg;
    localparam int DIGIT_W = 2;
    localparam logic [DIGIT_W-1:0] B3_INVALID = 2'b11;

    localparam logic [0:0] SER_IDLE  = 1'b0;
    localparam logic [0:0] SER_SHIFT = 1'b1;
endpackage

// File: rtl/b3_digit_check.sv
// Combinational base-3 word scrubber: forces illegal digit codes to zero and
// flags them, along with any set bit above the stored digit field.
module b3_digit_check
    import steg_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NDIGITS = 11
) (
    input  logic [2*WIDTH-1:0]         word_in,
    output logic [DIGIT_W*NDIGITS-1:0] word_out,
    output logic                       err_o
);
    logic bad_digit;
    logic hi_err;

    always_comb begin
        word_out  = word_in[DIGIT_W*NDIGITS-1:0];
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (word_in[DIGIT_W*i +: DIGIT_W] == B3_INVALID) begin
                word_out[DIGIT_W*i +: DIGIT_W] = '0;
                bad_digit = 1'b1;
            end
        end
    end

    generate
        if (NDIGITS < WIDTH) begin : g_hi
            assign hi_err = |word_in[2*WIDTH-1:DIGIT_W*NDIGITS];
        end else begin : g_no_hi
            assign hi_err = 1'b0;
        end
    endgenerate

    assign err_o = bad_digit | hi_err;
endmodule

// File: rtl/base3_digit_serializer.sv
// Serializes packed base-3 words into a fixed-length LSD-first digit stream.
// Define B3_DIGIT_CHECK_EN to scrub illegal digits and raise the sticky err flag.
module base3_digit_serializer
    import steg_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NDIGITS = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] base3_no,
    input  logic               done,
    output logic               conv_ready,
    output logic [1:0]         digit,
    output logic               digit_valid,
    input  logic               digit_ready,
    output logic               last,
    output logic               overflow,
    output logic               err
);
    localparam int WORD_W = DIGIT_W * NDIGITS;
    localparam int CNT_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

    logic [WORD_W-1:0] cap_word;
    logic              cap_err;

`ifdef B3_DIGIT_CHECK_EN
    b3_digit_check #(.WIDTH(WIDTH), .NDIGITS(NDIGITS)) u_check (
        .word_in (base3_no),
        .word_out(cap_word),
        .err_o   (cap_err)
    );
`else
    assign cap_word = base3_no[WORD_W-1:0];
    assign cap_err  = 1'b0;
    generate
        if (NDIGITS < WIDTH) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^base3_no[2*WIDTH-1:WORD_W];
        end
    endgenerate
`endif

    logic [0:0]        state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic              conv_ready_q, conv_ready_d;
    logic              overflow_q, overflow_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic [WORD_W-1:0] act_q, act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hs, at_last, move;

    always_comb begin
        state_d    = state_q;
        pend_v_d   = pend_v_q;
        pend_d     = pend_q;
        act_d      = act_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        move       = 1'b0;
        hs         = (state_q == SER_SHIFT) && digit_ready;
        at_last    = (cnt_q == LAST_CNT);

        case (state_q)
            SER_IDLE: begin
                if (pend_v_q) begin
                    move    = 1'b1;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (hs) begin
                    if (!at_last) begin
                        act_d = act_q >> DIGIT_W;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (pend_v_q) begin
                        move = 1'b1;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase

        if (move) begin
            act_d    = pend_q;
            cnt_d    = '0;
            pend_v_d = 1'b0;
        end

        // A slot being vacated this cycle may be refilled in the same cycle.
        if (done) begin
            if (!pend_v_q || move) begin
                pend_d   = cap_word;
                pend_v_d = 1'b1;
                err_d    = err_q | cap_err;
            end else begin
                overflow_d = 1'b1;
            end
        end

        conv_ready_d = !pend_v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SER_IDLE;
            pend_v_q     <= 1'b0;
            conv_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_v_q     <= pend_v_d;
            conv_ready_q <= conv_ready_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
        act_q  <= act_d;
        cnt_q  <= cnt_d;
    end

    assign digit_valid = (state_q == SER_SHIFT);
    assign digit       = digit_valid ? act_q[DIGIT_W-1:0] : '0;
    assign last        = digit_valid && at_last;
    assign conv_ready  = conv_ready_q;
    assign overflow    = overflow_q;
    assign err         = err_q;
endmodule

// File: tb/tb_base3_digit_serializer.sv
// Bench for base3_digit_serializer: transaction-level word/digit model plus
// directed literal scenarios and a randomized soak.
module tb_base3_digit_serializer;
    localparam int WIDTH = 16;
    localparam int ND    = 11;
    localparam int WW    = 2 * ND;

    logic               clk = 1'b0;
    logic               rst, done, digit_ready;
    logic [2*WIDTH-1:0] base3_no;
    logic               conv_ready, digit_valid, last, overflow, err;
    logic [1:0]         digit;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    int exp100[ND] = '{1, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    base3_digit_serializer #(.WIDTH(WIDTH), .NDIGITS(ND)) dut (
        .clk(clk), .rst(rst), .base3_no(base3_no), .done(done),
        .conv_ready(conv_ready), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .last(last), .overflow(overflow), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words held in the block (head may be on the stream), digit index of head.
    logic [WW-1:0] m_words[$];
    bit            m_loaded = 0;
    int            m_idx = 0;
    bit            m_ovf = 0;
    bit            m_err = 0;

    function automatic logic [WW-1:0] scrub(input logic [2*WIDTH-1:0] w, output bit bad);
        logic [WW-1:0] r;
        r   = w[WW-1:0];
        bad = 0;
`ifdef B3_DIGIT_CHECK_EN
        for (int k = 0; k < ND; k++) begin
            if (((w >> (2 * k)) & 3) == 3) begin
                r   = r & ~(WW'(3) << (2 * k));
                bad = 1;
            end
        end
        if ((w >> WW) != 0) bad = 1;
`endif
        return r;
    endfunction

    function automatic void m_step(input logic r, input logic d,
                                   input logic [2*WIDTH-1:0] w, input logic rdy);
        int pend;
        bit mv, bad;
        logic [WW-1:0] sw;
        if (r) begin
            m_words.delete();
            m_loaded = 0; m_idx = 0; m_ovf = 0; m_err = 0;
            return;
        end
        pend = m_words.size() - (m_loaded ? 1 : 0);
        mv = 0;
        if (!m_loaded) begin
            if (pend > 0) begin
                m_loaded = 1; m_idx = 0; mv = 1;
            end
        end else if (rdy) begin
            if (m_idx < ND - 1) m_idx++;
            else begin
                void'(m_words.pop_front());
                if (m_words.size() > 0) begin
                    m_idx = 0; mv = 1;
                end else m_loaded = 0;
            end
        end
        if (d === 1'b1) begin
            if (pend == 0 || mv) begin
                sw = scrub(w, bad);
                m_words.push_back(sw);
                if (bad) m_err = 1;
            end else m_ovf = 1;
        end
    endfunction

    always @(posedge clk) m_step(rst, done, base3_no, digit_ready);

    always @(negedge clk) begin
        logic [WW-1:0] h;
        int pend;
        if (chk_en) begin
            pend = m_words.size() - (m_loaded ? 1 : 0);
            chk("m_valid", int'(digit_valid), int'(m_loaded));
            chk("m_conv_ready", int'(conv_ready), int'(pend == 0));
            chk("m_overflow", int'(overflow), int'(m_ovf));
            chk("m_err", int'(err), int'(m_err));
            if (m_loaded && digit_valid) begin
                h = m_words[0];
                chk("m_digit", int'(digit), int'((h >> (2 * m_idx)) & 3));
                chk("m_last", int'(last), int'(m_idx == ND - 1));
            end
        end
    end

    task automatic run_word(input logic [2*WIDTH-1:0] w, input int stall_at,
                            input int stall_len, input int e[ND]);
        done = 1; base3_no = w;
        @(negedge clk);
        done = 0; base3_no = $urandom;
        chk("lat_captured_valid", int'(digit_valid), 0);
        chk("lat_captured_conv_ready", int'(conv_ready), 0);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk("word_valid", int'(digit_valid), 1);
            chk("word_digit", int'(digit), e[i]);
            chk("word_last", int'(last), int'(i == ND - 1));
            if (i == stall_at) begin
                digit_ready = 0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", int'(digit_valid), 1);
                    chk("stall_digit", int'(digit), e[i]);
                    chk("stall_last", int'(last), 0);
                end
                digit_ready = 1;
            end
            @(negedge clk);
        end
        chk("word_end_valid", int'(digit_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int got_d[$];
        int got_l[$];
        int got_c[$];
        int exp_bb[2*ND];

        rst = 1; done = 0; digit_ready = 1; base3_no = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("reset_valid", int'(digit_valid), 0);
        chk("reset_digit", int'(digit), 0);
        chk("reset_last", int'(last), 0);
        chk("reset_conv_ready", int'(conv_ready), 1);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_err", int'(err), 0);

        // Value 100, then the same word with a 3-cycle stall on its third digit.
        run_word(32'h121, -1, 0, exp100);
        run_word(32'h121, 2, 3, exp100);

        // Back-to-back second word, then a third word that must overflow.
        for (int k = 0; k < ND; k++) exp_bb[k] = exp100[k];
        exp_bb[ND] = 2;
        for (int k = ND + 1; k < 2 * ND; k++) exp_bb[k] = 0;
        for (int c = 0; c < 40; c++) begin
            if (digit_valid) begin
                got_d.push_back(int'(digit));
                got_l.push_back(int'(last));
                got_c.push_back(c);
            end
            if (c == 5) chk("bb_pend_full_conv_ready", int'(conv_ready), 0);
            if (c == 7) chk("ovf_set", int'(overflow), 1);
            done = (c == 0 || c == 4 || c == 6);
            base3_no = (c == 0) ? 32'h121 : (c == 4) ? 32'h2 : (c == 6) ? 32'h1 : $urandom;
            @(negedge clk);
        end
        done = 0;
        chk("bb_count", got_d.size(), 2 * ND);
        if (got_d.size() == 2 * ND) begin
            for (int k = 0; k < 2 * ND; k++) begin
                chk("bb_digit", got_d[k], exp_bb[k]);
                chk("bb_last", got_l[k], int'(k == ND - 1 || k == 2 * ND - 1));
                chk("bb_no_bubble", got_c[k], 2 + k);
            end
        end
        chk("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of a word discards it and clears the sticky flags.
        done = 1; base3_no = 32'h121;
        @(negedge clk);
        done = 0;
        repeat (4) @(negedge clk);
        chk("midword_valid_before_rst", int'(digit_valid), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_valid", int'(digit_valid), 0);
        chk("rst_mid_conv_ready", int'(conv_ready), 1);
        chk("rst_mid_overflow", int'(overflow), 0);
        chk("rst_mid_err", int'(err), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_discard_valid", int'(digit_valid), 0);
        end

        // Illegal digit code in position 0.
        done = 1; base3_no = 32'h3;
        @(negedge clk);
        done = 0;
        @(negedge clk);
        chk("inv_valid", int'(digit_valid), 1);
`ifdef B3_DIGIT_CHECK_EN
        chk("inv_digit", int'(digit), 0);
        chk("inv_err", int'(err), 1);
`else
        chk("inv_digit", int'(digit), 3);
        chk("inv_err", int'(err), 0);
`endif
        repeat (12) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 249) == 0);
            done        = ($urandom_range(0, 3) == 0);
            base3_no    = ($urandom_range(0, 3) == 0) ? $urandom : {16'h0, 16'($urandom)};
            digit_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        rst = 0; done = 0; digit_ready = 1;
        repeat (30) @(negedge clk);
        chk("drain_valid", int'(digit_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
